// File: rtl/multiport_register_file_if.sv
// Bus bundle for multiport_register_file: decode-stage read ports,
// two write-back ports and the flush handshake.
interface multiport_register_file_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
) ();
  logic [NUM_READ*ADDR_W-1:0] raddr;
  logic [NUM_READ*DATA_W-1:0] rdata;
  logic                       we0;
  logic                       we1;
  logic [ADDR_W-1:0]          waddr0;
  logic [ADDR_W-1:0]          waddr1;
  logic [DATA_W-1:0]          wdata0;
  logic [DATA_W-1:0]          wdata1;
  logic                       flush_req;
  logic                       flush_busy;
  logic                       flush_done;

  modport master (
    output raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, flush_req,
    input  rdata, flush_busy, flush_done
  );

  modport slave (
    input  raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, flush_req,
    output rdata, flush_busy, flush_done
  );
endinterface

// File: rtl/multiport_register_file.sv
// Parametrised MIPS register file: NUM_READ combinational read ports,
// two write ports (port 1 wins on address collision), optional same-cycle
// write-to-read bypass, optional hardwired zero register and a sequential
// scrub engine that clears one entry per cycle.
module multiport_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic                    clk,
  input logic                    rst,
  multiport_register_file_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    SCRUB
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic busy;
  logic wr_en0;
  logic wr_en1;

  assign busy = (state_q == SCRUB);

  // A write is dropped while scrubbing, and entry 0 is read-only when hardwired.
  assign wr_en0 = bus.we0 && !busy && !((ZERO_REG != 0) && (bus.waddr0 == '0));
  assign wr_en1 = bus.we1 && !busy && !((ZERO_REG != 0) && (bus.waddr1 == '0));

  assign bus.flush_busy = busy;
  assign bus.flush_done = done_q;

  // Flush engine: walk idx over every entry, pulse done after the last one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = SCRUB;
          idx_d   = '0;
        end
      end
      SCRUB: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == '1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage update: scrub clear, then port 0, then port 1 so port 1 wins.
  always_comb begin
    mem_d = mem_q;
    if (busy) begin
      mem_d[idx_q] = '0;
    end
    if (wr_en0) begin
      mem_d[bus.waddr0] = bus.wdata0;
    end
    if (wr_en1) begin
      mem_d[bus.waddr1] = bus.wdata1;
    end
  end

  // Read priority: zero register, scrub blanking, bypass (port 1 first), array.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = mem_q[a];
    if ((ZERO_REG != 0) && (a == '0)) begin
      v = '0;
    end else if (busy) begin
      v = '0;
    end else if ((BYPASS != 0) && wr_en1 && (bus.waddr1 == a)) begin
      v = bus.wdata1;
    end else if ((BYPASS != 0) && wr_en0 && (bus.waddr0 == a)) begin
      v = bus.wdata0;
    end
    return v;
  endfunction

  // Combinational read ports, one packed slice per port.
  always_comb begin
    bus.rdata = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      bus.rdata[k*DATA_W +: DATA_W] = read_port(bus.raddr[k*ADDR_W +: ADDR_W]);
    end
  end

  // State registers with synchronous active-low reset; reset aborts a scrub.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: stimulus pushes expected
// values, a negedge monitor pops and compares them against the DUT outputs.
module tb_multiport_register_file;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multiport_register_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) if_d ();
  multiport_register_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) if_n ();
  multiport_register_file_if #(.DATA_W(16), .ADDR_W(3), .NUM_READ(4)) if_s ();

  multiport_register_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)
  ) u_def (.clk(clk), .rst(rst), .bus(if_d));

  multiport_register_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(0)
  ) u_nobyp (.clk(clk), .rst(rst), .bus(if_n));

  multiport_register_file #(
    .DATA_W(16), .ADDR_W(3), .NUM_READ(4), .ZERO_REG(0), .BYPASS(1)
  ) u_sweep (.clk(clk), .rst(rst), .bus(if_s));

  // kind: 0 = rdata port, 1 = flush_busy, 2 = flush_done
  typedef struct {
    int          dut;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int dut, input int kind, input int port,
                          input logic [31:0] exp, input string name);
    chk_t c;
    c.dut  = dut;
    c.kind = kind;
    c.port = port;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  function automatic logic [31:0] actual(input int dut, input int kind, input int port);
    logic [31:0] v;
    v = '0;
    case (dut)
      0: case (kind)
           0:       v = if_d.rdata[port*32 +: 32];
           1:       v = {31'b0, if_d.flush_busy};
           default: v = {31'b0, if_d.flush_done};
         endcase
      1: case (kind)
           0:       v = if_n.rdata[port*32 +: 32];
           1:       v = {31'b0, if_n.flush_busy};
           default: v = {31'b0, if_n.flush_done};
         endcase
      default: case (kind)
           0:       v = {16'h0, if_s.rdata[port*16 +: 16]};
           1:       v = {31'b0, if_s.flush_busy};
           default: v = {31'b0, if_s.flush_done};
         endcase
    endcase
    return v;
  endfunction

  task automatic check_now(input logic [31:0] got, input logic [31:0] exp,
                           input string name);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wait_flag(input int dut, input int max_cycles, input string name);
    int unsigned n;
    logic        seen;
    seen = 1'b0;
    n_checks++;
    for (n = 0; n < max_cycles; n++) begin
      if (actual(dut, 2, 0) === 32'd1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: wait for flush_done expired after %0d cycles", name, max_cycles);
    end
  endtask

  // Monitor: outputs are settled by the falling edge; drain all pending checks.
  initial begin
    chk_t        c;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        c   = sb.pop_front();
        got = actual(c.dut, c.kind, c.port);
        n_checks++;
        if (got !== c.exp) begin
          n_fail++;
          $display("FAIL %s: dut%0d kind%0d port%0d got 0x%08h expected 0x%08h",
                   c.name, c.dut, c.kind, c.port, got, c.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic idle_all();
    if_d.we0 = 1'b0; if_d.we1 = 1'b0; if_d.flush_req = 1'b0;
    if_n.we0 = 1'b0; if_n.we1 = 1'b0; if_n.flush_req = 1'b0;
    if_s.we0 = 1'b0; if_s.we1 = 1'b0; if_s.flush_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_all();
    if_d.raddr = '0; if_d.waddr0 = '0; if_d.waddr1 = '0; if_d.wdata0 = '0; if_d.wdata1 = '0;
    if_n.raddr = '0; if_n.waddr0 = '0; if_n.waddr1 = '0; if_n.wdata0 = '0; if_n.wdata1 = '0;
    if_s.raddr = '0; if_s.waddr0 = '0; if_s.waddr1 = '0; if_s.wdata0 = '0; if_s.wdata1 = '0;
    // write during the reset cycle must be discarded
    if_d.we0 = 1'b1; if_d.waddr0 = 5'd12; if_d.wdata0 = 32'hFFFF_0000;
    tick();
    rst = 1'b1;
    idle_all();
    check_now({31'b0, if_d.flush_busy}, 32'd0, "reset_now_busy_d");
    check_now({31'b0, if_d.flush_done}, 32'd0, "reset_now_done_d");
    check_now({31'b0, if_n.flush_busy}, 32'd0, "reset_now_busy_n");
    check_now({31'b0, if_s.flush_busy}, 32'd0, "reset_now_busy_s");
    check_now({31'b0, if_s.flush_done}, 32'd0, "reset_now_done_s");

    // Reset state
    expect_v(0, 1, 0, 32'd0, "reset_busy");
    expect_v(0, 2, 0, 32'd0, "reset_done");
    for (int a = 0; a < 32; a++) begin
      if_d.raddr = {5'(31 - a), 5'(a)};
      expect_v(0, 0, 0, 32'd0, "reset_rd_p0");
      expect_v(0, 0, 1, 32'd0, "reset_rd_p1");
      tick();
    end

    // Zero register ignores writes, even on the bypass path
    if_d.we0 = 1'b1; if_d.waddr0 = 5'd0; if_d.wdata0 = 32'hDEAD_BEEF;
    if_d.raddr = {5'd0, 5'd0};
    expect_v(0, 0, 0, 32'd0, "zero_reg_same");
    tick();
    idle_all();
    expect_v(0, 0, 0, 32'd0, "zero_reg_after");
    tick();

    // Dual write, distinct addresses
    if_d.we0 = 1'b1; if_d.waddr0 = 5'd3; if_d.wdata0 = 32'h1111_1111;
    if_d.we1 = 1'b1; if_d.waddr1 = 5'd7; if_d.wdata1 = 32'h2222_2222;
    tick();
    idle_all();
    if_d.raddr = {5'd7, 5'd3};
    expect_v(0, 0, 0, 32'h1111_1111, "dual_r3");
    expect_v(0, 0, 1, 32'h2222_2222, "dual_r7");
    tick();

    // Dual write collision: port 1 wins, also on the bypass path
    if_d.we0 = 1'b1; if_d.waddr0 = 5'd9; if_d.wdata0 = 32'hAAAA_0000;
    if_d.we1 = 1'b1; if_d.waddr1 = 5'd9; if_d.wdata1 = 32'h5555_FFFF;
    if_d.raddr = {5'd9, 5'd9};
    expect_v(0, 0, 0, 32'h5555_FFFF, "collide_bypass");
    tick();
    idle_all();
    expect_v(0, 0, 0, 32'h5555_FFFF, "collide_r9_p0");
    expect_v(0, 0, 1, 32'h5555_FFFF, "collide_r9_p1");
    tick();

    // Bypass on: same-cycle forwarding
    if_d.we0 = 1'b1; if_d.waddr0 = 5'd5; if_d.wdata0 = 32'h1234_5678;
    if_d.raddr = {5'd0, 5'd5};
    expect_v(0, 0, 0, 32'h1234_5678, "bypass_same");
    tick();
    idle_all();
    expect_v(0, 0, 0, 32'h1234_5678, "bypass_next");
    tick();

    // Bypass off: old value in write cycle, new value next cycle
    if_n.we0 = 1'b1; if_n.waddr0 = 5'd5; if_n.wdata0 = 32'h0BAD_F00D;
    tick();
    if_n.we0 = 1'b1; if_n.waddr0 = 5'd5; if_n.wdata0 = 32'h1234_5678;
    if_n.raddr = {5'd0, 5'd5};
    expect_v(1, 0, 0, 32'h0BAD_F00D, "nobyp_old");
    tick();
    idle_all();
    expect_v(1, 0, 0, 32'h1234_5678, "nobyp_new");
    tick();

    // Flush: fill 1..31 with their index
    for (int a = 1; a < 32; a++) begin
      if_d.we0 = 1'b1; if_d.waddr0 = 5'(a); if_d.wdata0 = 32'(a);
      tick();
    end
    idle_all();
    if_d.raddr = {5'd17, 5'd31};
    expect_v(0, 0, 0, 32'd31, "fill_r31");
    expect_v(0, 0, 1, 32'd17, "fill_r17");
    tick();
    if_d.flush_req = 1'b1;
    tick();
    if_d.flush_req = 1'b0;
    if_d.raddr = {5'd2, 5'd5};
    if_d.we0 = 1'b1; if_d.waddr0 = 5'd2; if_d.wdata0 = 32'hFFFF_FFFF;
    if_d.we1 = 1'b1; if_d.waddr1 = 5'd5; if_d.wdata1 = 32'hEEEE_EEEE;
    for (int i = 0; i < 32; i++) begin
      expect_v(0, 1, 0, 32'd1, "flush_busy_hi");
      expect_v(0, 2, 0, 32'd0, "flush_done_lo");
      expect_v(0, 0, 0, 32'd0, "flush_rd_p0");
      expect_v(0, 0, 1, 32'd0, "flush_rd_p1");
      tick();
    end
    idle_all();
    expect_v(0, 1, 0, 32'd0, "flush_busy_end");
    expect_v(0, 2, 0, 32'd1, "flush_done_pulse");
    tick();
    expect_v(0, 2, 0, 32'd0, "flush_done_once");
    for (int a = 0; a < 32; a++) begin
      if_d.raddr = {5'(31 - a), 5'(a)};
      expect_v(0, 0, 0, 32'd0, "post_flush_p0");
      expect_v(0, 0, 1, 32'd0, "post_flush_p1");
      tick();
    end

    // Reset mid-flush
    if_d.we0 = 1'b1; if_d.waddr0 = 5'd20; if_d.wdata0 = 32'h2020_2020;
    if_d.we1 = 1'b1; if_d.waddr1 = 5'd4;  if_d.wdata1 = 32'h0404_0404;
    tick();
    idle_all();
    if_d.flush_req = 1'b1;
    tick();
    if_d.flush_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_now({31'b0, if_d.flush_busy}, 32'd0, "rstmid_now_busy");
    check_now(if_d.rdata[63:32], 32'd0, "rstmid_now_rd");
    expect_v(0, 1, 0, 32'd0, "rstmid_busy");
    expect_v(0, 2, 0, 32'd0, "rstmid_done");
    if_d.we0 = 1'b1; if_d.waddr0 = 5'd4; if_d.wdata0 = 32'h4444_4444;
    if_d.raddr = {5'd20, 5'd4};
    expect_v(0, 0, 0, 32'h4444_4444, "rstmid_wr_bypass");
    expect_v(0, 0, 1, 32'd0, "rstmid_r20_cleared");
    tick();
    idle_all();
    expect_v(0, 0, 0, 32'h4444_4444, "rstmid_wr_stored");
    expect_v(0, 2, 0, 32'd0, "rstmid_no_done");
    tick();
    expect_v(0, 2, 0, 32'd0, "rstmid_no_done2");
    tick();

    // Parameter sweep: entry 0 writable, 8-cycle flush
    if_s.we0 = 1'b1; if_s.waddr0 = 3'd0; if_s.wdata0 = 16'hBEEF;
    tick();
    idle_all();
    if_s.raddr = '0;
    for (int p = 0; p < 4; p++) begin
      expect_v(2, 0, p, 32'h0000_BEEF, "sweep_r0");
    end
    tick();
    if_s.flush_req = 1'b1;
    tick();
    if_s.flush_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_v(2, 1, 0, 32'd1, "sweep_busy_hi");
      tick();
    end
    expect_v(2, 1, 0, 32'd0, "sweep_busy_end");
    expect_v(2, 2, 0, 32'd1, "sweep_done_pulse");
    wait_flag(2, 1, "sweep_done_wait");
    tick();
    for (int p = 0; p < 4; p++) begin
      expect_v(2, 0, p, 32'd0, "sweep_r0_cleared");
    end
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised general-purpose register file for the MIPS pipeline: configurable data width, depth and read-port count, two write-back ports with a fixed collision priority, optional write-to-read bypass, optional hardwired zero register, and a sequential flush engine with a busy/done handshake. It sits between the decode stage (read ports) and the write-back stage (write ports). It is the next-generation replacement for the single-write, two-read register file.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, 1: entry 0 reads 0 and ignores writes
- BYPASS, 1, 1: same-cycle write data is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- raddr  in  NUM_READ*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_READ*DATA_W  packed read data, same packing
- we0, we1  in  1 each  write enables, port 0 and port 1
- waddr0, waddr1  in  ADDR_W each  write addresses
- wdata0, wdata1  in  DATA_W each  write data
- flush_req  in  1  request to clear all entries
- flush_busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse when flush completes

## Operation
- Write is effective when weN=1, flush_busy=0, and not (ZERO_REG=1 and waddrN=0).
- Both writes effective to the same address: port 1 wins, and port 0 is dropped. Different addresses: both are written in the same cycle.
- Read path is combinational from raddr.
  - ZERO_REG=1 and address 0: rdata = 0.
  - Else if flush_busy=1: rdata = 0.
  - Else if BYPASS=1 and an effective write targets the address: rdata = that write data. If both ports are effective to that address, port 1 data is used.
  - Else: rdata = stored entry.
- BYPASS=0: a write becomes visible on reads in the cycle after the edge that stores it.
- Flush engine FSM, states IDLE and SCRUB, with counter idx[ADDR_W-1:0]:
  - IDLE, flush_req=1: go to SCRUB, idx=0.
  - SCRUB: each cycle clear entry idx, then increment idx. On the edge that clears entry DEPTH-1, go to IDLE and assert flush_done for the following cycle.
  - flush_req is ignored while in SCRUB. flush_req held high after completion starts a new flush, because it is re-sampled in IDLE.
- flush_busy = (state == SCRUB).

## Timing
- Reset (rst=0 at a rising edge): all entries = 0, state = IDLE, idx = 0, flush_busy = 0, flush_done = 0.
  - Writes in the reset cycle are discarded.
  - rdata after reset is 0 for every address.
  - Reset asserted mid-flush aborts the flush immediately, with no flush_done pulse.
- Write latency: the entry is updated at the rising edge where the write is effective. With BYPASS=1, read data reflects the write in that same cycle (0-cycle forwarding).
- Flush latency:
  - Request sampled at edge T.
  - flush_busy is high from T through the edge T+DEPTH.
  - flush_done is high in the cycle after edge T+DEPTH.
  - Total time is DEPTH cycles busy; the earliest next effective write is at edge T+DEPTH+1.
- flush_req and a write asserted in the same IDLE cycle: the write is effective at edge T and is then cleared by the flush.
- idx wraps naturally: DEPTH-1 is the final entry, and there is no out-of-range access.
- No combinational path from flush_req to rdata. The only combinational paths are raddr/we/waddr/wdata to rdata.

## Test plan
- Reset and zero register (defaults): drive rst=0 for 1 cycle, then read all 32 addresses -> each returns 0x00000000. Write 0xDEADBEEF to address 0 -> reading address 0 still returns 0.
- Dual write: we0=we1=1, waddr0=3/wdata0=0x11111111, waddr1=7/wdata1=0x22222222 -> next cycle r3=0x11111111 and r7=0x22222222. Repeat with both ports targeting address 9 (0xAAAA0000 vs 0x5555FFFF) -> r9=0x5555FFFF.
- Bypass: BYPASS=1, raddr port0=5, write 0x12345678 to address 5 -> rdata port0=0x12345678 in the same cycle. With BYPASS=0 -> old value in the same cycle, new value the next cycle.
- Flush: fill entries 1..31 with the value of their index, pulse flush_req -> flush_busy high for exactly 32 cycles, rdata=0 throughout, writes ignored, flush_done pulses once; afterwards all entries read 0.
- Reset mid-flush: assert rst=0 at cycle 10 of a flush -> flush_busy=0 on the next cycle, no flush_done pulse, all entries 0, and a normal write to address 4 succeeds in the first cycle after rst returns high.
- Parameter sweep: DATA_W=16, ADDR_W=3, NUM_READ=4, ZERO_REG=0 -> entry 0 is writable (0xBEEF read back on all four ports), and a flush takes 8 cycles.
